// File: rtl/psum_join_acc_pkg.sv
// Shared constants and helpers for the multi-core partial-sum join/accumulate unit.
// The PSUM_SAT_EN build uses the saturation bound helpers below.
package psum_pkg;

  localparam int NCORE_DEF = 2;
  localparam int SW_DEF    = 24;
  localparam int DEPTH_DEF = 4;
  localparam int CNTW_DEF  = 8;

  // Joined total width: one extra bit per doubling of the core count, so no overflow.
  function automatic int out_width(input int sw, input int ncore);
    return sw + $clog2(ncore);
  endfunction

  function automatic longint sat_hi(input int sw);
    return (longint'(1) << (sw - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int sw);
    return -(longint'(1) << (sw - 1));
  endfunction

endpackage

// File: rtl/psum_join_acc_if.sv
// Channel bundle of psum_join_acc: NCORE input valid/ready channels plus one output channel.
// sat_flag exists only when PSUM_SAT_EN is defined.
interface psum_join_acc_if
  import psum_pkg::*;
#(
  parameter int NCORE = NCORE_DEF,
  parameter int SW    = SW_DEF,
  parameter int CNTW  = CNTW_DEF,
  parameter int OW    = out_width(SW, NCORE)
);
  logic [NCORE*SW-1:0] in_sum;
  logic [NCORE-1:0]    in_valid;
  logic [NCORE-1:0]    in_ready;
  logic [OW-1:0]       out_sum;
  logic                out_valid;
  logic                out_ready;
  logic [CNTW-1:0]     row_cnt;
`ifdef PSUM_SAT_EN
  logic                sat_flag;
`endif

  modport master (
    output in_sum, in_valid, out_ready,
    input  in_ready, out_sum, out_valid, row_cnt
`ifdef PSUM_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  in_sum, in_valid, out_ready,
    output in_ready, out_sum, out_valid, row_cnt
`ifdef PSUM_SAT_EN
    , output sat_flag
`endif
  );
endinterface

// File: rtl/psum_join_acc_fifo.sv
// Per-channel synchronous FIFO with registered head read; a pushed entry becomes
// visible at the head one cycle after its push edge.
module psum_chan_fifo #(
  parameter int SW    = 24,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [SW-1:0] din_i,
  input  logic          pop_i,
  output logic [SW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [SW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_vis_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] head_q;
  logic          do_push, do_pop;

  // Full counts every written entry; empty uses the one-cycle-delayed write pointer
  // so the head register has already captured the entry when it is declared present.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (rd_ptr_q == wr_vis_q);
  assign head_o  = head_q;

  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + PW'(do_push);
  assign rd_ptr_d = rd_ptr_q + PW'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      wr_vis_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      wr_vis_q <= wr_ptr_q;
      rd_ptr_q <= rd_ptr_d;
      head_q   <= mem_q[rd_ptr_d[AW-1:0]];
    end
  end
endmodule

// File: rtl/psum_join_acc.sv
// Joins NCORE per-core row sums through per-channel FIFOs and emits their signed total.
// Define PSUM_SAT_EN to clamp the total to the SW-bit range and add sat_flag.
module psum_join_acc
  import psum_pkg::*;
#(
  parameter int NCORE = NCORE_DEF,
  parameter int SW    = SW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input logic             clk,
  input logic             reset,
  psum_join_acc_if.slave  bus
);
  localparam int OW = out_width(SW, NCORE);

  logic [NCORE-1:0]       full;
  logic [NCORE-1:0]       empty;
  logic [SW-1:0]          head [NCORE];
  logic signed [OW-1:0]   acc  [NCORE];
  logic signed [OW-1:0]   sum;
  logic signed [OW-1:0]   res;
  logic                   all_present;
  logic                   accept;
  logic                   fire;

  logic [OW-1:0]          out_sum_q, out_sum_d;
  logic                   out_valid_q, out_valid_d;
  logic [CNTW-1:0]        row_cnt_q, row_cnt_d;

  assign all_present = ~|empty;
  assign accept      = out_valid_q && bus.out_ready;
  assign fire        = all_present && (!out_valid_q || bus.out_ready);

  for (genvar gi = 0; gi < NCORE; gi++) begin : g_chan
    psum_chan_fifo #(
      .SW    (SW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (bus.in_valid[gi]),
      .din_i   (bus.in_sum[gi*SW +: SW]),
      .pop_i   (fire),
      .head_o  (head[gi]),
      .full_o  (full[gi]),
      .empty_o (empty[gi])
    );

    // Running sum across channels, each head sign-extended to the full output width.
    if (gi == 0) begin : g_first
      assign acc[gi] = {{(OW-SW){head[gi][SW-1]}}, head[gi]};
    end else begin : g_rest
      assign acc[gi] = acc[gi-1] + {{(OW-SW){head[gi][SW-1]}}, head[gi]};
    end
  end

  assign sum          = acc[NCORE-1];
  assign bus.in_ready = ~full;

`ifdef PSUM_SAT_EN
  localparam logic signed [OW-1:0] SAT_HI = OW'(sat_hi(SW));
  localparam logic signed [OW-1:0] SAT_LO = OW'(sat_lo(SW));

  logic sat;
  logic sat_flag_q, sat_flag_d;

  always_comb begin
    res = sum;
    sat = 1'b0;
    if (sum > SAT_HI) begin
      res = SAT_HI;
      sat = 1'b1;
    end else if (sum < SAT_LO) begin
      res = SAT_LO;
      sat = 1'b1;
    end
  end

  always_comb begin
    sat_flag_d = sat_flag_q;
    if (fire) begin
      sat_flag_d = sat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_flag_q <= 1'b0;
    end else begin
      sat_flag_q <= sat_flag_d;
    end
  end

  assign bus.sat_flag = sat_flag_q;
`else
  assign res = sum;
`endif

  // A fire in the same cycle as an accept replaces the result, keeping one row per cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_sum_d   = res;
    end else if (accept) begin
      out_valid_d = 1'b0;
    end
    row_cnt_d = row_cnt_q + CNTW'(accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      row_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      row_cnt_q   <= row_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.row_cnt   = row_cnt_q;
endmodule

// File: tb/tb_psum_join_acc.sv
// Testbench for psum_join_acc: directed table, skew, backpressure, reset and random streaming.
module tb_psum_join_acc;
  localparam int NCORE = 2;
  localparam int SW    = 24;
  localparam int DEPTH = 4;
  localparam int CNTW  = 8;

  logic clk = 1'b0;
  logic reset;

  psum_join_acc_if #(.NCORE(NCORE), .SW(SW), .CNTW(CNTW)) bus ();

  psum_join_acc #(
    .NCORE (NCORE),
    .SW    (SW),
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint a;
    longint b;
    longint exp_sum;
    longint exp_sat;
    bit     exp_flag;
  } vec_t;

  vec_t   vecs [7];
  int     n_tests = 0;
  int     n_fail  = 0;
  longint ch0_q[$];
  longint ch1_q[$];
  longint exp_q[$];
  int     rows_model = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint model_res(input longint s);
`ifdef PSUM_SAT_EN
    if (s > 64'sd8388607)  return 64'sd8388607;
    if (s < -64'sd8388608) return -64'sd8388608;
`endif
    return s;
  endfunction

  function automatic longint out_val();
    return longint'($signed(bus.out_sum));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input longint a, input longint b, input logic [1:0] v);
    logic [SW-1:0] ra;
    logic [SW-1:0] rb;
    ra = SW'(a);
    rb = SW'(b);
    bus.in_sum   = {rb, ra};
    bus.in_valid = v;
  endtask

  // Presents one beat for a cycle; returns the ready seen before the edge.
  task automatic drive_cycle(input longint a, input longint b, input logic [1:0] v,
                             output logic [1:0] rdy);
    set_in(a, b, v);
    @(negedge clk);
    rdy = bus.in_ready;
    tick();
  endtask

  task automatic drain(input string name, input int budget);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && c < budget) begin
      tick();
      c++;
    end
    n_tests++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s: drain timeout, %0d rows still expected", name, exp_q.size());
    end
  endtask

  // Reference model, sampled mid-cycle: records handshakes that the next edge commits.
  always @(negedge clk) begin
    if (reset) begin
      ch0_q.delete();
      ch1_q.delete();
      exp_q.delete();
      rows_model = 0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mon_row: unexpected result %0d, expected none", out_val());
        end else begin
          check("mon_row", out_val(), exp_q.pop_front());
        end
        rows_model++;
      end
      if (bus.in_valid[0] && bus.in_ready[0])
        ch0_q.push_back(longint'($signed(bus.in_sum[SW-1:0])));
      if (bus.in_valid[1] && bus.in_ready[1])
        ch1_q.push_back(longint'($signed(bus.in_sum[2*SW-1:SW])));
      while (ch0_q.size() != 0 && ch1_q.size() != 0)
        exp_q.push_back(model_res(ch0_q.pop_front() + ch1_q.pop_front()));
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]    rdy;
    logic [SW-1:0] r;
    int            k, c, rows_before, sent0, sent1;
    logic [1:0]    v;
    longint        v0, v1;

    vecs[0] = '{100, -30, 70, 70, 1'b0};
    vecs[1] = '{0, 0, 0, 0, 1'b0};
    vecs[2] = '{-5, 3, -2, -2, 1'b0};
    vecs[3] = '{8388607, 8388607, 16777214, 8388607, 1'b1};
    vecs[4] = '{-8388608, -8388608, -16777216, -8388608, 1'b1};
    vecs[5] = '{8388607, 1, 8388608, 8388607, 1'b1};
    vecs[6] = '{-8388608, 8388607, -1, -1, 1'b0};

    reset         = 1'b1;
    bus.in_sum    = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_out_valid", longint'(bus.out_valid), 0);
    check("rst_out_sum", out_val(), 0);
    check("rst_row_cnt", longint'(bus.row_cnt), 0);
    check("rst_in_ready", longint'(bus.in_ready), 3);

    // Directed table: both channels push on one edge, result two cycles later.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      set_in(vecs[i].a, vecs[i].b, 2'b11);
      tick();
      bus.in_valid = 2'b00;
      check($sformatf("vec%0d_lat1", i), longint'(bus.out_valid), 0);
      tick();
      check($sformatf("vec%0d_lat2", i), longint'(bus.out_valid), 0);
      tick();
      check($sformatf("vec%0d_valid", i), longint'(bus.out_valid), 1);
`ifdef PSUM_SAT_EN
      check($sformatf("vec%0d_sum", i), out_val(), vecs[i].exp_sat);
      check($sformatf("vec%0d_flag", i), longint'(bus.sat_flag), longint'(vecs[i].exp_flag));
`else
      check($sformatf("vec%0d_sum", i), out_val(), vecs[i].exp_sum);
`endif
      tick();
      check($sformatf("vec%0d_done", i), longint'(bus.out_valid), 0);
      check($sformatf("vec%0d_row_cnt", i), longint'(bus.row_cnt), longint'(i + 1));
      $display("[TB] vec %0d: %0d + %0d -> %0d", i, vecs[i].a, vecs[i].b, out_val());
    end

    // Skewed arrival: ch0 fills its FIFO before ch1 supplies anything.
    for (int i = 0; i < 4; i++) begin
      drive_cycle(longint'(5 + i), 0, 2'b01, rdy);
      check($sformatf("skew_push%0d_rdy", i), longint'(rdy[0]), 1);
    end
    bus.in_valid = 2'b00;
    check("skew_full", longint'(bus.in_ready), 2);
    check("skew_no_out", longint'(bus.out_valid), 0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(0, 1, 2'b10, rdy);
    end
    bus.in_valid = 2'b00;
    drain("skew", 50);
    check("skew_ready_back", longint'(bus.in_ready), 3);
    check("skew_row_cnt", longint'(bus.row_cnt), 11);
    $display("[TB] skew: rows=%0d row_cnt=%0d", rows_model, bus.row_cnt);

    // Backpressure: stall the output until both FIFOs are full.
    rows_before   = rows_model;
    bus.out_ready = 1'b0;
    k = 0;
    c = 0;
    while (k < 5 && c < 20) begin
      drive_cycle(longint'(10 * k + 1), longint'(k), 2'b11, rdy);
      if (rdy == 2'b11) k++;
      c++;
    end
    bus.in_valid = 2'b00;
    check("bp_pushed", longint'(k), 5);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", i), longint'(bus.out_valid), 1);
      check($sformatf("bp_hold_sum%0d", i), out_val(), 1);
      check($sformatf("bp_in_ready%0d", i), longint'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    drain("bp", 50);
    check("bp_rows", longint'(rows_model - rows_before), 5);
    check("bp_row_cnt", longint'(bus.row_cnt), 16);
    $display("[TB] backpressure: rows=%0d row_cnt=%0d", rows_model - rows_before, bus.row_cnt);

    // Reset with one result held and three rows buffered.
    bus.out_ready = 1'b0;
    k = 0;
    c = 0;
    while (k < 4 && c < 20) begin
      drive_cycle(longint'(k + 100), longint'(k), 2'b11, rdy);
      if (rdy == 2'b11) k++;
      c++;
    end
    bus.in_valid = 2'b00;
    tick();
    check("mid_rst_pre_valid", longint'(bus.out_valid), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", longint'(bus.out_valid), 0);
    check("mid_rst_row_cnt", longint'(bus.row_cnt), 0);
    check("mid_rst_in_ready", longint'(bus.in_ready), 3);
    check("mid_rst_sum", out_val(), 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("mid_rst_stale%0d", i), longint'(bus.out_valid), 0);
    end
    $display("[TB] mid-op reset: row_cnt=%0d out_valid=%0d", bus.row_cnt, bus.out_valid);

    // Random streaming: 300 rows per channel with random valid and out_ready.
    sent0 = 0;
    sent1 = 0;
    c = 0;
    r = SW'($urandom);
    v0 = longint'($signed(r));
    r = SW'($urandom);
    v1 = longint'($signed(r));
    while ((sent0 < 300 || sent1 < 300) && c < 20000) begin
      v[0] = (sent0 < 300) && ($urandom_range(0, 3) != 0);
      v[1] = (sent1 < 300) && ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      drive_cycle(v0, v1, v, rdy);
      if (v[0] && rdy[0]) begin
        sent0++;
        r = SW'($urandom);
        v0 = longint'($signed(r));
      end
      if (v[1] && rdy[1]) begin
        sent1++;
        r = SW'($urandom);
        v1 = longint'($signed(r));
      end
      c++;
    end
    bus.in_valid  = 2'b00;
    bus.out_ready = 1'b1;
    check("rand_sent0", longint'(sent0), 300);
    check("rand_sent1", longint'(sent1), 300);
    drain("rand", 100);
    check("rand_rows", longint'(rows_model), 300);
    check("rand_row_cnt", longint'(bus.row_cnt), 44);
    $display("[TB] random: rows=%0d row_cnt=%0d cycles=%0d", rows_model, bus.row_cnt, c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
